jts16_mapper_gen: RTL and testbench



---
 rtl/jts16_mapper_pkg.sv | 38 +++
 rtl/jts16_mapper_wait.sv | 64 ++++++
 rtl/jts16_mapper_gen.sv | 138 +++++++++++++
 tb/tb_jts16_mapper_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jts16_mapper_pkg.sv
// Shared constants, enums and the region match function for the jts16 memory mapper.
package jts16_mapper_pkg;

    localparam int MMR_N      = 32;
    localparam int CTRL_BASE  = 16;
    localparam int SNDIDX_DEF = 3;

    typedef enum logic [1:0] {
        SZ_64K  = 2'd0,
        SZ_128K = 2'd1,
        SZ_512K = 2'd2,
        SZ_2M   = 2'd3
    } size_e;

    localparam int CTL_WP       = 2;
    localparam int CTL_WAIT_LSB = 3;
    localparam int CTL_EXT      = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_EXT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } wst_e;

    // addr is the word address [23:1], so byte bit k sits at addr[k-1]
    function automatic logic region_match(input logic [7:0] ctrl, input logic [7:0] base,
                                          input logic [22:0] addr);
        case (size_e'(ctrl[1:0]))
            SZ_64K:  return addr[22:15] == base;
            SZ_128K: return addr[22:16] == base[7:1];
            SZ_512K: return addr[22:18] == base[7:3];
            default: return addr[22:20] == base[7:5];
        endcase
    endfunction

endpackage

// File: rtl/jts16_mapper_wait.sv
// DTACK wait-state / bus-error FSM; advances on cen, but releases on asn high every clk.
module jts16_mapper_wait import jts16_mapper_pkg::*; #(
    parameter int WAITW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cen_i,
    input  logic             asn_i,
    input  logic [1:0]       dswn_i,
    input  logic [WAITW-1:0] wait_i,
    input  logic             ext_i,
    input  logic             wp_i,
    input  logic             edackn_i,
    output logic             dtackn_o,
    output logic             berrn_o,
    output wst_e             state_o
);

    wst_e             state_q, state_d;
    logic [WAITW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (asn_i) begin
            state_d = ST_IDLE;
        end else if (cen_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (wp_i && dswn_i != 2'b11)
                        state_d = ST_ERR;
                    else if (wait_i == '0)
                        state_d = ext_i ? ST_EXT : ST_ACK;
                    else begin
                        cnt_d   = wait_i;
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAITW'(1))
                        state_d = ext_i ? ST_EXT : ST_ACK;
                end
                ST_EXT: if (!edackn_i) state_d = ST_ACK;
                default: ;
            endcase
        end
    end

    assign dtackn_o = state_q != ST_ACK;
    assign berrn_o  = state_q != ST_ERR;
    assign state_o  = state_q;

endmodule

// File: rtl/jts16_mapper_gen.sv
// Parametrised S16B-style memory mapper: region decode, wait states, WP bus error, sound latch, VBLANK IRQ.
// Define JTS16_MAPPER_STATUS_EN to add the registered st_addr_i/st_dout_o status read port.
module jts16_mapper_gen import jts16_mapper_pkg::*; #(
    parameter int NREG    = 8,
    parameter int WAITW   = 4,
    parameter int IRQ_LVL = 4,
    parameter int SNDIDX  = SNDIDX_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_cen_i,
    input  logic [22:0]     addr_i,
    input  logic [15:0]     cpu_dout_i,
    input  logic [1:0]      cpu_dswn_i,
    input  logic            cpu_asn_i,
    input  logic [2:0]      cpu_fc_i,
    input  logic            edackn_i,
    input  logic            vint_i,
    output logic            cpu_dtackn_o,
    output logic            cpu_berrn_o,
    output logic [2:0]      cpu_ipln_o,
    output logic            cpu_vpan_o,
    output logic [NREG-1:0] active_o,
    input  logic            sndmap_rd_i,
    output logic [7:0]      sndmap_dout_o,
    output logic            sndmap_obf_o,
    input  logic [4:0]      mcu_addr_i,
    input  logic [7:0]      mcu_dout_i,
    input  logic            mcu_wr_i,
    output logic [1:0]      mcu_intn_o
`ifdef JTS16_MAPPER_STATUS_EN
    ,
    input  logic [7:0]      st_addr_i,
    output logic [7:0]      st_dout_o
`endif
);

    logic [MMR_N-1:0][7:0] mmr_q;
    logic                  owner_q, obf_q, pend_q, vint_q;
    logic [NREG-1:0]       hit, active;
    logic [7:0]            sel_ctrl;
    logic                  wr_en, snd_wr, iack;
    logic [4:0]            wr_idx;
    logic [7:0]            wr_dat;
    wst_e                  wst;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        assign hit[r] = region_match(mmr_q[CTRL_BASE+2*r], mmr_q[CTRL_BASE+2*r+1], addr_i);
    end

    // two's-complement trick isolates the lowest set bit: lowest region wins
    assign active   = (cpu_fc_i == 3'd7) ? '0 : (hit & (~hit + NREG'(1)));
    assign active_o = active;

    always_comb begin
        sel_ctrl = '0;
        for (int r = 0; r < NREG; r++)
            if (active[r]) sel_ctrl = sel_ctrl | mmr_q[CTRL_BASE+2*r];
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_dat = '0;
        if (mcu_wr_i) begin
            wr_en  = 1'b1;
            wr_idx = mcu_addr_i;
            wr_dat = mcu_dout_i;
        end else if (owner_q && !cpu_asn_i && !cpu_dswn_i[0] && active == '0) begin
            wr_en  = 1'b1;
            wr_idx = addr_i[4:0];
            wr_dat = cpu_dout_i[7:0];
        end
    end

    assign snd_wr = wr_en && wr_idx == 5'(SNDIDX);
    assign iack   = cpu_fc_i == 3'd7 && !cpu_asn_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mmr_q   <= '0;
            owner_q <= 1'b1;
            obf_q   <= 1'b0;
            pend_q  <= 1'b0;
            vint_q  <= 1'b0;
        end else begin
            if (wr_en) mmr_q[wr_idx] <= wr_dat;
            if (mcu_wr_i) owner_q <= 1'b0;
            if (snd_wr) obf_q <= 1'b1;
            else if (sndmap_rd_i) obf_q <= 1'b0;
            vint_q <= vint_i;
            if (vint_i && !vint_q) pend_q <= 1'b1;
            else if (iack) pend_q <= 1'b0;
        end
    end

    jts16_mapper_wait #(.WAITW(WAITW)) u_wait (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cen_i    (cpu_cen_i),
        .asn_i    (cpu_asn_i),
        .dswn_i   (cpu_dswn_i),
        .wait_i   (sel_ctrl[CTL_WAIT_LSB +: WAITW]),
        .ext_i    (sel_ctrl[CTL_EXT]),
        .wp_i     (sel_ctrl[CTL_WP]),
        .edackn_i (edackn_i),
        .dtackn_o (cpu_dtackn_o),
        .berrn_o  (cpu_berrn_o),
        .state_o  (wst)
    );

    assign cpu_ipln_o    = pend_q ? ~3'(IRQ_LVL) : 3'b111;
    assign cpu_vpan_o    = ~iack;
    assign sndmap_dout_o = mmr_q[SNDIDX];
    assign sndmap_obf_o  = obf_q;
    assign mcu_intn_o    = {1'b1, ~pend_q};

`ifdef JTS16_MAPPER_STATUS_EN
    logic [7:0] st_q;
    logic       unused_sig;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            st_q <= '0;
        else if (st_addr_i[4])
            st_q <= {2'b00, wst, pend_q, obf_q, owner_q};
        else
            st_q <= mmr_q[{1'b1, st_addr_i[2:0], st_addr_i[3]}];
    end

    assign st_dout_o  = st_q;
    assign unused_sig = ^{cpu_dout_i[15:8], st_addr_i[7:5]};
`else
    logic unused_sig;
    assign unused_sig = ^{cpu_dout_i[15:8], wst};
`endif

endmodule

// File: tb/tb_jts16_mapper_gen.sv
// Directed bench for jts16_mapper_gen: decode priority, wait states, ext DTACK, WP, sound latch, IRQ, ownership.
module tb_jts16_mapper_gen;

    localparam int NREG = 8;

    logic            clk = 1'b0, rst = 1'b1, cen = 1'b0;
    logic [22:0]     addr = '0;
    logic [15:0]     dout = '0;
    logic [1:0]      dswn = 2'b11;
    logic            asn = 1'b1;
    logic [2:0]      fc = 3'd0;
    logic            edackn = 1'b1, vint = 1'b0, sndrd = 1'b0;
    logic [4:0]      maddr = '0;
    logic [7:0]      mdout = '0;
    logic            mwr = 1'b0;
    logic            dtackn, berrn, vpan, obf;
    logic [2:0]      ipln;
    logic [NREG-1:0] active;
    logic [7:0]      snd;
    logic [1:0]      mintn;
`ifdef JTS16_MAPPER_STATUS_EN
    logic [7:0]      st_addr = '0;
    logic [7:0]      st_dout;
`endif

    int n_chk = 0, n_fail = 0;

    jts16_mapper_gen #(.NREG(NREG), .WAITW(4), .IRQ_LVL(4), .SNDIDX(3)) dut (
        .clk_i(clk), .rst_i(rst), .cpu_cen_i(cen), .addr_i(addr), .cpu_dout_i(dout),
        .cpu_dswn_i(dswn), .cpu_asn_i(asn), .cpu_fc_i(fc), .edackn_i(edackn), .vint_i(vint),
        .cpu_dtackn_o(dtackn), .cpu_berrn_o(berrn), .cpu_ipln_o(ipln), .cpu_vpan_o(vpan),
        .active_o(active), .sndmap_rd_i(sndrd), .sndmap_dout_o(snd), .sndmap_obf_o(obf),
        .mcu_addr_i(maddr), .mcu_dout_i(mdout), .mcu_wr_i(mwr), .mcu_intn_o(mintn)
`ifdef JTS16_MAPPER_STATUS_EN
        , .st_addr_i(st_addr), .st_dout_o(st_dout)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) cen = ~cen;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [22:0] ba(input logic [23:0] b);
        return b[23:1];
    endfunction

    // register writes go to byte 0x40xxxx, which no configured region decodes
    task automatic cpu_wr(input int idx, input logic [7:0] v);
        addr = 23'h200000 | 23'(idx); dout = {8'h00, v}; dswn = 2'b10; asn = 1'b0;
        tick(); tick();
        asn = 1'b1; dswn = 2'b11;
        tick();
    endtask

    task automatic mcu_w(input logic [4:0] idx, input logic [7:0] v);
        maddr = idx; mdout = v; mwr = 1'b1;
        tick();
        mwr = 1'b0;
    endtask

    // cen edges seen with asn low up to and including the one that drops DTACK; -1 on timeout
    task automatic measure(input logic [23:0] b, output int ncen);
        bit got = 0;
        addr = ba(b); dswn = 2'b11; asn = 1'b0; ncen = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (cen) ncen++;
            if (!dtackn) got = 1;
        end
        if (!got) ncen = -1;
        asn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_chk++; if (dtackn !== 1'b1) begin n_fail++; $display("FAIL rst_dtackn got %b want 1", dtackn); end
        n_chk++; if (berrn !== 1'b1) begin n_fail++; $display("FAIL rst_berrn got %b want 1", berrn); end
        n_chk++; if (ipln !== 3'b111) begin n_fail++; $display("FAIL rst_ipln got %b want 111", ipln); end
        n_chk++; if (vpan !== 1'b1) begin n_fail++; $display("FAIL rst_vpan got %b want 1", vpan); end
        n_chk++; if (obf !== 1'b0) begin n_fail++; $display("FAIL rst_obf got %b want 0", obf); end
        n_chk++; if (mintn !== 2'b11) begin n_fail++; $display("FAIL rst_mcu_intn got %b want 11", mintn); end
        n_chk++; if (snd !== 8'h00) begin n_fail++; $display("FAIL rst_snd got %h want 00", snd); end
        n_chk++; if (active !== 8'h01) begin n_fail++; $display("FAIL rst_active got %h want 01", active); end
    endtask

    task automatic test_priority();
        cpu_wr(16, 8'h02); cpu_wr(17, 8'h20);
        cpu_wr(18, 8'h02); cpu_wr(19, 8'h20);
        addr = ba(24'h200000); #1;
        n_chk++; if (active !== 8'h01) begin n_fail++; $display("FAIL prio_r0 got %h want 01", active); end
        cpu_wr(17, 8'h00);
        addr = ba(24'h200000); #1;
        n_chk++; if (active !== 8'h02) begin n_fail++; $display("FAIL prio_r1 got %h want 02", active); end
        addr = ba(24'h27FFFE); #1;
        n_chk++; if (active !== 8'h02) begin n_fail++; $display("FAIL r1_top got %h want 02", active); end
        addr = ba(24'h280000); #1;
        n_chk++; if (active !== 8'h00) begin n_fail++; $display("FAIL r1_above got %h want 00", active); end
    endtask

    task automatic test_wait();
        int n;
        cpu_wr(20, 8'h18); cpu_wr(21, 8'h30);
        cpu_wr(26, 8'h00); cpu_wr(27, 8'h31);
        measure(24'h300000, n);
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL wait3_cens got %0d want 4", n); end
        measure(24'h310000, n);
        n_chk++; if (n !== 1) begin n_fail++; $display("FAIL wait0_cens got %0d want 1", n); end
    endtask

    task automatic test_ext();
        bit early = 0, hitcen = 0;
        cpu_wr(22, 8'h80); cpu_wr(23, 8'h32);
        addr = ba(24'h320000); edackn = 1'b1; asn = 1'b0;
        repeat (20) begin tick(); if (!dtackn) early = 1; end
        n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL ext_hold dtackn fell early got %b want 0", early); end
        edackn = 1'b0;
        for (int i = 0; i < 4 && !hitcen; i++) begin tick(); if (cen) hitcen = 1; end
        n_chk++; if (dtackn !== 1'b0) begin n_fail++; $display("FAIL ext_ack got %b want 0", dtackn); end
        asn = 1'b1; edackn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_wp();
        bit got = 0;
        cpu_wr(24, 8'h04); cpu_wr(25, 8'h33);
        addr = ba(24'h330000); dswn = 2'b10; asn = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); if (!berrn) got = 1; end
        n_chk++; if (berrn !== 1'b0) begin n_fail++; $display("FAIL wp_berr got %b want 0", berrn); end
        n_chk++; if (dtackn !== 1'b1) begin n_fail++; $display("FAIL wp_dtack got %b want 1", dtackn); end
        asn = 1'b1; dswn = 2'b11;
        tick();
        n_chk++; if ({berrn, dtackn} !== 2'b11) begin n_fail++; $display("FAIL wp_release got %b want 11", {berrn, dtackn}); end
        got = 0; asn = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); if (!dtackn) got = 1; end
        n_chk++; if (dtackn !== 1'b0) begin n_fail++; $display("FAIL wp_read_dtack got %b want 0", dtackn); end
        n_chk++; if (berrn !== 1'b1) begin n_fail++; $display("FAIL wp_read_berr got %b want 1", berrn); end
        asn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_sound();
        cpu_wr(3, 8'h5A);
        n_chk++; if (obf !== 1'b1) begin n_fail++; $display("FAIL snd_obf_set got %b want 1", obf); end
        n_chk++; if (snd !== 8'h5A) begin n_fail++; $display("FAIL snd_data got %h want 5a", snd); end
        sndrd = 1'b1; tick(); sndrd = 1'b0; tick();
        n_chk++; if (obf !== 1'b0) begin n_fail++; $display("FAIL snd_obf_clr got %b want 0", obf); end
        addr = ba(24'h400006); dout = 16'h00A5; dswn = 2'b10; asn = 1'b0; sndrd = 1'b1;
        tick();
        asn = 1'b1; dswn = 2'b11; sndrd = 1'b0;
        n_chk++; if (obf !== 1'b1) begin n_fail++; $display("FAIL snd_wr_rd_obf got %b want 1", obf); end
        n_chk++; if (snd !== 8'hA5) begin n_fail++; $display("FAIL snd_data2 got %h want a5", snd); end
        tick();
    endtask

    task automatic test_irq();
        vint = 1'b1; tick();
        n_chk++; if (ipln !== 3'b011) begin n_fail++; $display("FAIL irq_set got %b want 011", ipln); end
        n_chk++; if (mintn !== 2'b10) begin n_fail++; $display("FAIL irq_mcu got %b want 10", mintn); end
        vint = 1'b0; tick();
        fc = 3'd7; asn = 1'b0; vint = 1'b1;
        tick();
        n_chk++; if (ipln !== 3'b011) begin n_fail++; $display("FAIL irq_same_clk got %b want 011", ipln); end
        n_chk++; if (vpan !== 1'b0) begin n_fail++; $display("FAIL iack_vpan got %b want 0", vpan); end
        tick();
        n_chk++; if (ipln !== 3'b111) begin n_fail++; $display("FAIL irq_ack_clr got %b want 111", ipln); end
        asn = 1'b1; fc = 3'd0; vint = 1'b0;
        tick();
        n_chk++; if (vpan !== 1'b1) begin n_fail++; $display("FAIL vpan_release got %b want 1", vpan); end
    endtask

    task automatic test_owner();
        mcu_w(5'd3, 8'h77);
        n_chk++; if (snd !== 8'h77) begin n_fail++; $display("FAIL mcu_wr got %h want 77", snd); end
        sndrd = 1'b1; tick(); sndrd = 1'b0;
        cpu_wr(3, 8'h99);
        n_chk++; if ({obf, snd} !== {1'b0, 8'h77}) begin n_fail++; $display("FAIL cpu_ignored got %b/%h want 0/77", obf, snd); end
        cpu_wr(17, 8'h20);
        addr = ba(24'h200000); #1;
        n_chk++; if (active !== 8'h02) begin n_fail++; $display("FAIL cpu_ignored_map got %h want 02", active); end
    endtask

    task automatic test_rst_mid();
        bit got = 0;
        addr = ba(24'h310000); asn = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); if (!dtackn) got = 1; end
        rst = 1'b1;
        tick();
        n_chk++; if (dtackn !== 1'b1) begin n_fail++; $display("FAIL rst_mid_dtack got %b want 1", dtackn); end
        rst = 1'b0; asn = 1'b1;
        tick();
        n_chk++; if (snd !== 8'h00) begin n_fail++; $display("FAIL rst_mid_mmr got %h want 00", snd); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_wait();
        test_ext();
        test_wp();
        test_sound();
        test_irq();
        test_owner();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
